serial_sub_ctrl: RTL and testbench
==================================

// Module: serial_sub_ctrl
// PURPOSE
//  Bit-serial subtraction controller: sequences one 1-bit subtractor cell over WIDTH cycles
//  to compute a - b, LSB first, with a registered borrow chain.
//  Sits between a host issuing start/operands and the 1-bit subtractor datapath.
//  Trades latency for area: one cell reused instead of WIDTH ripple cells.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..64
// PORTS
//  clk         in   1      rising-edge clock; the block's only clock
//  rst_n       in   1      reset, asynchronous assert, active-low
//  start       in   1      request; sampled only when busy=0
//  a           in   WIDTH  minuend; captured on an accepted start
//  b           in   WIDTH  subtrahend; captured on an accepted start
//  busy        out  1      high from the cycle after an accepted start through the done cycle
//  done        out  1      single-cycle pulse; diff/borrow_out are valid from this cycle on
//  diff        out  WIDTH  registered result (a - b) mod 2^WIDTH
//  borrow_out  out  1      registered final borrow: 1 iff a < b (unsigned)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; busy=0; done=0; diff=0; borrow_out=0; shift regs, count and bor cleared.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE: on start=1, load sa<=a, sb<=b, bor<=0, count<=0, then go to SHIFT. Otherwise hold.
//   SHIFT: each cycle the cell evaluates (sa[0], sb[0], bor).
//    d = sa^sb^bor
//    bnext = (~sa&sb) | (~(sa^sb)&bor)
//    d is shifted into the result shift register from the MSB side; sa and sb shift right; bor<=bnext.
//    count increments. When count==WIDTH-1, go to DONE.
//   DONE: diff<=result, borrow_out<=bnext of the final bit, and done=1 for exactly one cycle.
//    Always returns to IDLE on the next cycle.
//  Latency: start accepted at edge N -> done high in cycle N+WIDTH+1.
//   Next start is accepted no earlier than the IDLE cycle after done.
//  start is ignored while busy=1; it is not queued, and a/b changes while busy have no effect.
//  diff/borrow_out hold their last result until the next DONE; they are never cleared by start.
//  rst_n asserted mid-operation aborts immediately: all state and outputs return to their reset values.
//   No done is emitted for the aborted operation.
//  count width is $clog2(WIDTH). No wrap-around beyond WIDTH-1 occurs.
//  Equal operands give diff=0, borrow_out=0. Borrow out of the MSB is reported, never dropped.
// STRUCTURE
//  Shared package sub_pkg:
//   - state enum localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2
//   - function clog2w for the counter width
//  One sub-module, sub_bit_cell: a combinational 1-bit full subtractor (a, b, bin -> d, bout),
//   composed from two half-subtractor stages plus an OR.
//  Controller top holds the FSM, the counter, three WIDTH-bit shift registers and the borrow flop.
// TESTING
//  WIDTH=8, a=8'd5, b=8'd3, start pulse -> done exactly 9 cycles after the accept edge;
//   diff=8'h02, borrow_out=0.
//  a=8'd3, b=8'd5 -> diff=8'hFE, borrow_out=1. Also a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1.
//  a=b=8'hFF, and a=b=8'h00 -> diff=0, borrow_out=0. busy high for 9 cycles, done high for 1.
//  start re-pulsed with a=8'hAA during SHIFT of 5-3 -> ignored; result is still 8'h02;
//   only one done pulse.
//  rst_n low for 1 cycle at count=4 of an operation -> busy/done/diff/borrow_out=0 immediately;
//   a fresh start then gives the correct result.
//  Back-to-back: start held high continuously -> operations complete every 10 cycles.
//   Exhaustive WIDTH=4 sweep of all 256 (a,b) pairs matches a reference model.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtraction controller:
// FSM state encoding and the counter-width helper.
package sub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_SHIFT = 2'd1;
    localparam state_t S_DONE  = 2'd2;

    // Bits needed to count 0..w-1, never less than one.
    function automatic int clog2w(input int w);
        int r;
        r = 0;
        while ((1 << r) < w) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// Combinational 1-bit full subtractor built from two half-subtractor
// stages whose borrows are ORed together.
module sub_bit_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    assign d1   = a ^ b;
    assign b1   = ~a & b;
    assign d    = d1 ^ bin;
    assign b2   = ~d1 & bin;
    assign bout = b1 | b2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one sub_bit_cell reused over WIDTH cycles to form
// a - b LSB first, with a registered borrow chain between bits.
module serial_sub_ctrl
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int            CW   = clog2w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    count;
    logic             bor;
    logic             d;
    logic             bnext;
    logic             accept;
    logic             last_bit;

    sub_bit_cell u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (bor),
        .d    (d),
        .bout (bnext)
    );

    assign accept   = (state == S_IDLE) && start;
    assign last_bit = (state == S_SHIFT) && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_SHIFT;
            S_SHIFT: if (count == LAST) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_SHIFT: busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand/result shifting; the final bit is folded straight into diff
    // so the result is already valid in the cycle done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            count      <= '0;
            bor        <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (accept) begin
            sa    <= a;
            sb    <= b;
            bor   <= 1'b0;
            count <= '0;
        end else if (state == S_SHIFT) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            res <= {d, res[WIDTH-1:1]};
            bor <= bnext;
            if (last_bit) begin
                diff       <= {d, res[WIDTH-1:1]};
                borrow_out <= bnext;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed vectors, multi-cycle
// corner cases, randomized operations and an exhaustive 4-bit sweep.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       borrow4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
    );

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       bor;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one 8-bit operation from an IDLE sample point and follow it until
    // busy drops. lat is the cycle index (1 = first cycle after the accept edge)
    // of the first done pulse, -1 if none arrived within the bound.
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input bit scramble,
                       output int lat, output int bcyc, output int dcyc);
        lat  = -1;
        bcyc = 0;
        dcyc = 0;
        a = ia;
        b = ib;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (scramble) begin
                a = 8'($urandom);
                b = 8'($urandom);
                start = (k < 8) ? 1'($urandom) : 1'b0;
            end
            if (busy) bcyc++;
            if (done) begin
                dcyc++;
                if (lat < 0) lat = k;
            end
            if (lat > 0 && !busy) break;
            tick();
        end
        start = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        int lat, bcyc, dcyc, ndone;
        int t[$];
        logic [7:0] ra, rb;

        vecs[0] = '{8'd5,   8'd3,   8'h02, 1'b0};
        vecs[1] = '{8'd3,   8'd5,   8'hFE, 1'b1};
        vecs[2] = '{8'h00,  8'h01,  8'hFF, 1'b1};
        vecs[3] = '{8'hFF,  8'hFF,  8'h00, 1'b0};
        vecs[4] = '{8'h00,  8'h00,  8'h00, 1'b0};
        vecs[5] = '{8'h80,  8'h7F,  8'h01, 1'b0};
        vecs[6] = '{8'h00,  8'hFF,  8'h01, 1'b1};

        // Reset state
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            op8(vecs[i].a, vecs[i].b, 1'b0, lat, bcyc, dcyc);
            check($sformatf("vec%0d_diff", i), diff, vecs[i].diff);
            check($sformatf("vec%0d_borrow", i), borrow_out, vecs[i].bor);
            check($sformatf("vec%0d_latency", i), lat, 9);
            check($sformatf("vec%0d_busy_cycles", i), bcyc, 9);
            check($sformatf("vec%0d_done_cycles", i), dcyc, 1);
        end

        // start re-pulsed with other operands mid-operation must be ignored
        a = 8'd5; b = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 3) begin
                start = 1'b1; a = 8'hAA; b = 8'h00;
            end else begin
                start = 1'b0;
            end
            if (done) ndone++;
            tick();
        end
        check("ignore_start_diff", diff, 8'h02);
        check("ignore_start_borrow", borrow_out, 0);
        check("ignore_start_dones", ndone, 1);
        check("ignore_start_idle", busy, 0);

        // Reset mid-operation at count=4
        a = 8'd5; b = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow_out, 0);
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) ndone++;
            tick();
        end
        check("abort_no_done", ndone, 0);
        op8(8'd3, 8'd5, 1'b0, lat, bcyc, dcyc);
        check("after_abort_diff", diff, 8'hFE);
        check("after_abort_borrow", borrow_out, 1);
        check("after_abort_latency", lat, 9);

        // Back-to-back with start held high
        a = 8'd9; b = 8'd4; start = 1'b1;
        for (int k = 0; k < 45; k++) begin
            tick();
            if (done) begin
                t.push_back(k);
                check("b2b_diff", diff, 8'd5);
            end
        end
        start = 1'b0;
        check("b2b_done_count_ok", (t.size() >= 4), 1);
        for (int i = 1; i < t.size(); i++)
            check("b2b_interval", t[i] - t[i-1], 10);
        for (int k = 0; k < 12 && busy; k++) tick();
        check("b2b_back_idle", busy, 0);

        // Randomized operations with operand/start noise while busy
        for (int n = 0; n < 150; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            op8(ra, rb, 1'b1, lat, bcyc, dcyc);
            check("rand_diff", diff, 8'(ra - rb));
            check("rand_borrow", borrow_out, (ra < rb));
            check("rand_latency", lat, 9);
        end

        // Exhaustive WIDTH=4 sweep
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                int k;
                a4 = 4'(ia);
                b4 = 4'(ib);
                start4 = 1'b1;
                tick();
                start4 = 1'b0;
                for (k = 0; k < 12 && !done4; k++) tick();
                check("w4_latency", k, 4);
                check("w4_diff", diff4, (ia - ib) & 15);
                check("w4_borrow", borrow4, (ia < ib));
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
